// File: rtl/wb_stage_if.sv
// MEM->WB bundle: MEM-stage instruction fields, raw load data, pipeline control and WB results.
// Latency: none, this is wiring only; the stage adds one cycle from MEM fields to WB results.
// Backpressure: stall holds the stage, flush inserts a bubble; both are driven by the pipeline controller.
interface wb_stage_if #(
  parameter int DATA_WITDH = 32,
  parameter int ADDR_WITDH = 32
);
  logic                  stall;
  logic                  flush;
  logic                  valid_m;
  logic                  reg_wem;
  logic [4:0]            rdm;
  logic [2:0]            opm;
  logic [1:0]            wb_ctrm;
  logic [ADDR_WITDH-1:0] pcnm;
  logic [DATA_WITDH-1:0] alu_resultm;
  logic [DATA_WITDH-1:0] rdata_raw;
  logic                  reg_ww;
  logic [4:0]            rdw;
  logic [DATA_WITDH-1:0] wdata_w;
  logic                  valid_w;
  logic [63:0]           instret;

  // Pipeline side: supplies MEM fields and control, consumes writeback results.
  modport master (
    output stall, flush, valid_m, reg_wem, rdm, opm, wb_ctrm, pcnm, alu_resultm, rdata_raw,
    input  reg_ww, rdw, wdata_w, valid_w, instret
  );

  // Writeback stage side.
  modport slave (
    input  stall, flush, valid_m, reg_wem, rdm, opm, wb_ctrm, pcnm, alu_resultm, rdata_raw,
    output reg_ww, rdw, wdata_w, valid_w, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load align/extend, writeback select, retired-instruction counter (WB_INSTRET_EN).
// Latency: 1 cycle from MEM fields to WB outputs; wdata_w is combinational from the register and the raw or held load data.
// Backpressure: stall freezes the register and parks the sync-RAM word in hold_data; flush loads a bubble even while stalled.
module wb_stage #(
  parameter int DATA_WITDH = 32,
  parameter int ADDR_WITDH = 32
) (
  input logic     clk,
  input logic     rst,
  wb_stage_if.slave bus
);

  logic                  valid_q;
  logic                  reg_we_q;
  logic [4:0]            rd_q;
  logic [2:0]            op_q;
  logic [1:0]            ctr_q;
  logic [ADDR_WITDH-1:0] pcn_q;
  logic [DATA_WITDH-1:0] alu_q;

  // The data RAM only presents the load word in the first WB cycle, so it is parked here across a stall.
  logic                  hold_vld;
  logic [DATA_WITDH-1:0] hold_data;

  logic [DATA_WITDH-1:0] load_word;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_WITDH-1:0] load_data;
  logic [DATA_WITDH-1:0] wdata;

  // MEM/WB pipeline register: reset, then bubble, then hold, then capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
      rd_q     <= 5'd0;
      op_q     <= 3'd0;
      ctr_q    <= 2'd0;
      pcn_q    <= '0;
      alu_q    <= '0;
    end else if (bus.flush) begin
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
    end else if (!bus.stall) begin
      valid_q  <= bus.valid_m;
      reg_we_q <= bus.reg_wem;
      rd_q     <= bus.rdm;
      op_q     <= bus.opm;
      ctr_q    <= bus.wb_ctrm;
      pcn_q    <= bus.pcnm;
      alu_q    <= bus.alu_resultm;
    end
  end

  // Capture the raw word on the first stalled edge; release it on the first non-stalled edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (bus.stall) begin
      if (!hold_vld) begin
        hold_vld  <= 1'b1;
        hold_data <= bus.rdata_raw;
      end
    end else begin
      hold_vld <= 1'b0;
    end
  end

  // Lane pick from the registered address offset, then sign/zero extension by load type.
  always_comb begin
    load_word = hold_vld ? hold_data : bus.rdata_raw;
    byte_lane = 8'd0;
    case (alu_q[1:0])
      2'd0:    byte_lane = load_word[7:0];
      2'd1:    byte_lane = load_word[15:8];
      2'd2:    byte_lane = load_word[23:16];
      default: byte_lane = load_word[31:24];
    endcase
    half_lane = alu_q[1] ? load_word[31:16] : load_word[15:0];
    case (op_q)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_data = {24'd0, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b101:  load_data = {16'd0, half_lane};
      default: load_data = load_word;
    endcase
  end

  // Writeback select; 11 aliases the ALU path.
  always_comb begin
    case (ctr_q)
      2'b01:   wdata = load_data;
      2'b10:   wdata = DATA_WITDH'(pcn_q);
      default: wdata = alu_q;
    endcase
  end

  assign bus.wdata_w = wdata;
  assign bus.valid_w = valid_q;
  assign bus.rdw     = rd_q;
  assign bus.reg_ww  = valid_q & reg_we_q & (rd_q != 5'd0);

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Count each instruction once, on the edge it leaves WB unstalled; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_q <= 64'd0;
    end else if (valid_q && !bus.stall) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign bus.instret = instret_q;
`else
  assign bus.instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: stimulus queues expected WB outputs tagged with the cycle they must appear in.
// A negedge monitor pops and compares, and flags any valid_w that nothing expected.
// Instret expectations collapse to zero unless WB_INSTRET_EN is defined.
module tb_wb_stage;

  bit          clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  wb_stage_if #(.DATA_WITDH(32), .ADDR_WITDH(32)) bus ();

  wb_stage #(.DATA_WITDH(32), .ADDR_WITDH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef WB_INSTRET_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  typedef struct {
    int          cyc;
    string       name;
    logic        vld;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    bit          chk_data;
    bit          chk_ret;
    logic [63:0] ret;
  } exp_t;

  exp_t q[$];
  exp_t e;

  // Load table against raw word 0x80FF7F01 (bytes 01,7F,FF,80 from lane 0 up).
  logic [2:0]  ld_op  [12] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 3'b001,
                               3'b100, 3'b101, 3'b001, 3'b010, 3'b011, 3'b110};
  logic [31:0] ld_adr [12] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h102, 32'h102,
                               32'h103, 32'h103, 32'h100, 32'h101, 32'h102, 32'h103};
  logic [31:0] ld_exp [12] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                               32'h000080FF, 32'hFFFF80FF, 32'h00000080, 32'h000080FF,
                               32'h00007F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};

  function automatic logic [63:0] r(input logic [63:0] v);
    return RET_EN ? v : 64'd0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_at(input int c, input string n, input logic v, input logic we,
                           input logic [4:0] rd, input logic [31:0] wd,
                           input bit cd, input bit cr, input logic [63:0] ret);
    exp_t x;
    x.cyc = c; x.name = n; x.vld = v; x.we = we; x.rd = rd; x.wd = wd;
    x.chk_data = cd; x.chk_ret = cr; x.ret = ret;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_m     = 1'b0;
    bus.reg_wem     = 1'b0;
    bus.rdm         = 5'd0;
    bus.opm         = 3'd0;
    bus.wb_ctrm     = 2'd0;
    bus.pcnm        = 32'd0;
    bus.alu_resultm = 32'd0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] op, input logic [1:0] ctr,
                       input logic [31:0] pcn, input logic [31:0] alu);
    bus.valid_m     = 1'b1;
    bus.reg_wem     = 1'b1;
    bus.rdm         = rd;
    bus.opm         = op;
    bus.wb_ctrm     = ctr;
    bus.pcnm        = pcn;
    bus.alu_resultm = alu;
  endtask

  // Monitor: compare whatever is due this cycle; an unannounced valid_w is an error.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: expectation for cycle %0d never observed", e.name, e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk({e.name, ".valid_w"}, 64'(bus.valid_w), 64'(e.vld));
      chk({e.name, ".reg_ww"},  64'(bus.reg_ww),  64'(e.we));
      if (e.chk_data) begin
        chk({e.name, ".rdw"},     64'(bus.rdw),     64'(e.rd));
        chk({e.name, ".wdata_w"}, 64'(bus.wdata_w), 64'(e.wd));
      end
      if (e.chk_ret) chk({e.name, ".instret"}, bus.instret, e.ret);
    end else if (cyc > 0 && bus.valid_w !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_valid: valid_w=%b at cycle %0d, expected 0", bus.valid_w, cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.stall = 1'b1;
    bus.flush = 1'b0;
    bus.rdata_raw = 32'd0;
    idle();

    // Reset for two edges; stall is ignored while in reset.
    tick();
    expect_at(cyc, "reset1", 0, 0, 5'd0, 32'd0, 1, 1, 64'd0);
    bus.stall = 1'b0;
    tick();
    expect_at(cyc, "reset2", 0, 0, 5'd0, 32'd0, 1, 1, 64'd0);
    rst = 1'b1;
    expect_at(cyc + 1, "idle", 0, 0, 5'd0, 32'd0, 1, 1, 64'd0);
    tick();

    // ALU writeback, then the same to x0 (write suppressed).
    issue(5'd5, 3'b010, 2'b00, 32'h0, 32'h1234);
    expect_at(cyc + 1, "alu_rd5", 1, 1, 5'd5, 32'h1234, 1, 0, 64'd0);
    tick();
    issue(5'd0, 3'b010, 2'b00, 32'h0, 32'h55);
    expect_at(cyc + 1, "alu_rd0", 1, 0, 5'd0, 32'h55, 1, 0, 64'd0);
    tick();

    // Load alignment, back to back.
    bus.rdata_raw = 32'h80FF7F01;
    for (int i = 0; i < 12; i++) begin
      issue(5'd3, ld_op[i], 2'b01, 32'h0, ld_adr[i]);
      expect_at(cyc + 1, $sformatf("load%0d", i), 1, 1, 5'd3, ld_exp[i], 1, 0, 64'd0);
      tick();
    end
    idle();
    expect_at(cyc + 1, "drain", 0, 0, 5'd0, 32'd0, 1, 0, 64'd0);
    tick();

    // Fresh reset so instret counts from zero, then LW held through 3 stalled cycles.
    rst = 1'b0;
    tick();
    expect_at(cyc, "reset3", 0, 0, 5'd0, 32'd0, 1, 1, 64'd0);
    rst = 1'b1;
    issue(5'd7, 3'b010, 2'b01, 32'h0, 32'h200);
    expect_at(cyc + 1, "lw_stall0", 1, 1, 5'd7, 32'h11223344, 1, 1, 64'd0);
    tick();
    bus.stall = 1'b1;
    bus.rdata_raw = 32'h11223344;
    issue(5'd9, 3'b000, 2'b00, 32'h0, 32'h999);
    expect_at(cyc + 1, "lw_stall1", 1, 1, 5'd7, 32'h11223344, 1, 1, 64'd0);
    tick();
    bus.rdata_raw = 32'hDEADBEEF;
    expect_at(cyc + 1, "lw_stall2", 1, 1, 5'd7, 32'h11223344, 1, 1, 64'd0);
    tick();
    expect_at(cyc + 1, "lw_stall3", 1, 1, 5'd7, 32'h11223344, 1, 1, 64'd0);
    tick();
    bus.stall = 1'b0;
    expect_at(cyc + 1, "after_stall", 1, 1, 5'd9, 32'h999, 1, 1, r(64'd1));
    tick();

    // Reset arriving in the middle of a stall clears fields and the held word.
    issue(5'd8, 3'b010, 2'b01, 32'h0, 32'h300);
    expect_at(cyc + 1, "lw8", 1, 1, 5'd8, 32'hCAFEF00D, 1, 1, r(64'd2));
    tick();
    bus.rdata_raw = 32'hCAFEF00D;
    bus.stall = 1'b1;
    idle();
    expect_at(cyc + 1, "lw8_held", 1, 1, 5'd8, 32'hCAFEF00D, 1, 1, r(64'd2));
    tick();
    bus.rdata_raw = 32'h0;
    rst = 1'b0;
    expect_at(cyc + 1, "reset_mid_stall", 0, 0, 5'd0, 32'd0, 1, 1, 64'd0);
    tick();
    rst = 1'b1;
    bus.stall = 1'b0;
    issue(5'd4, 3'b100, 2'b01, 32'h0, 32'h301);
    expect_at(cyc + 1, "lbu_after_reset", 1, 1, 5'd4, 32'h000000AB, 1, 1, 64'd0);
    tick();
    bus.rdata_raw = 32'h0000AB00;

    // Flush together with stall still yields a bubble; no retirement while stalled.
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    issue(5'd10, 3'b000, 2'b00, 32'h0, 32'h77);
    expect_at(cyc + 1, "flush_stall", 0, 0, 5'd0, 32'd0, 0, 1, 64'd0);
    tick();
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // JAL writes PC+4; instret preset to all-ones wraps when it retires.
    issue(5'd1, 3'b000, 2'b10, 32'h00000104, 32'hBAD);
    expect_at(cyc + 1, "jal", 1, 1, 5'd1, 32'h00000104, 1, 1, r(64'hFFFF_FFFF_FFFF_FFFF));
    tick();
`ifdef WB_INSTRET_EN
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
`endif
    idle();
    expect_at(cyc + 1, "instret_wrap", 0, 0, 5'd0, 32'd0, 1, 1, 64'd0);
    tick();
    tick();
    tick();

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
